// File: rtl/bridge_req_arbiter.sv
// Round-robin arbiter that shares one four-phase req/ack bridge stage
// among N_REQ clocked requesters, one complete handshake per grant.
module bridge_req_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic [N_REQ-1:0]          done_o,
    output logic                      err_o,
    output logic                      busy_o,
    output logic                      bridge_req,
    output logic [DATA_W-1:0]         bridge_data,
    input  logic                      bridge_ack
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RAISE,
        RELEASE,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   ack_s;
    logic [TW-1:0]          timer;
    logic                   expired;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          gidx;
    logic [IW-1:0]          win;
    logic                   found;
    logic                   err_flag;
    logic                   err_n;

    assign ack_s   = sync[SYNC_STAGES-1];
    assign expired = (timer == TW'(TIMEOUT_CYC));

    // First asserted request at ptr, ptr+1, ... wraps modulo N_REQ.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        err_n   = err_flag;
        unique case (state)
            IDLE: begin
                if (found && !ack_s) state_n = RAISE;
            end
            RAISE: begin
                if (ack_s) begin
                    state_n = RELEASE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_n = DONE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                err_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            err_flag    <= 1'b0;
            sync        <= '0;
            timer       <= '0;
            ptr         <= '0;
            gidx        <= '0;
            grant_o     <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            bridge_req  <= 1'b0;
            bridge_data <= '0;
        end else begin
            state      <= state_n;
            err_flag   <= err_n;
            sync       <= {sync[SYNC_STAGES-2:0], bridge_ack};
            bridge_req <= (state == RAISE);
            busy_o     <= (state_n != IDLE);
            done_o     <= (state_n == DONE) ? grant_o : '0;
            err_o      <= (state_n == DONE) && err_n;

            if (state_n != state)
                timer <= '0;
            else if (state == RAISE || state == RELEASE)
                timer <= timer + 1'b1;

            if (state == IDLE && state_n == RAISE) begin
                gidx        <= win;
                grant_o     <= N_REQ'(1) << win;
                bridge_data <= data_i[win*DATA_W +: DATA_W];
            end

            // Owner releases the bridge; the next one in line gets priority.
            if (state == DONE) begin
                grant_o <= '0;
                ptr     <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

endmodule
